tt_um_nibble_add_seq: RTL and testbench
=======================================

TT_UM_NIBBLE_ADD_SEQ -- requirements
Module: tt_um_nibble_add_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; release is synchronous to clk.
REQ-003 ena  input  1  when high, state advances normally; when low, every register holds its value.
REQ-004 ui_in  input  8  operand beat: [3:0] = nibble of A, [7:4] = nibble of B.
REQ-005 uio_in  input  8  bit0 in_valid; bit2 out_ready; bit4 abort; bit6 carry_in; bits 1, 3, 5 and 7 are ignored.
REQ-006 uio_out  output  8  bit1 in_ready; bit3 out_valid; bit5 busy; all other bits are 0.
REQ-007 uio_oe  output  8  constant 8'b0010_1010, so only bits 1, 3 and 5 are driven.
REQ-008 uo_out  output  8  [3:0] result nibble; [4] final carry; [6:5] read nibble index; [7] = out_valid.

Function
REQ-009 Block shall sequence one shared 4-bit adder (nibble A + nibble B + carry) to perform a 16-bit add over four beats, least-significant nibble first.
REQ-010 FSM shall have two states:
- LOAD: accepting operand beats.
- OUT: presenting the result.
REQ-011 In LOAD: in_ready=1, out_valid=0. In OUT: in_ready=0, out_valid=1.
REQ-012 Operand beat shall transfer on a rising edge when in_valid=1, in_ready=1 and ena=1.
REQ-013 On each beat k (k = 0..3, held in a 2-bit write index):
- sum = A[3:0] + B[3:0] + c, computed at 5-bit width.
- sum[3:0] is stored to result slot k.
- sum[4] becomes the new c.
REQ-014 For beat 0, c shall be uio_in[6] sampled in that cycle; for beats 1-3, c is the stored carry from the previous beat.
REQ-015 Beat 3 shall store the final carry and move the FSM to OUT on the same edge; read index is set to 0.
REQ-016 In OUT:
- uo_out[3:0] shall show result slot [read index].
- uo_out[6:5] shall show the read index.
- uo_out[4] shall show the final carry.
REQ-017 In OUT, each edge with out_ready=1 and ena=1 shall increment the read index.
REQ-018 On the fourth accepted read (index 3), the FSM shall return to LOAD with write index 0 and carry 0.
REQ-019 out_ready=0 shall hold the current nibble indefinitely (backpressure).
REQ-020 in_valid in OUT shall be ignored, with no state change. out_ready in LOAD shall be ignored.
REQ-021 Sum wraps modulo 2^16; overflow is reported only through the final carry.
REQ-022 busy shall be 1 when state=OUT or write index is not 0; otherwise 0.
REQ-023 abort=1 (with ena=1) shall, on that edge, return to LOAD and clear write index, read index, carry and all result slots.
REQ-024 abort shall take priority over any simultaneous beat or read.
REQ-025 In LOAD, uo_out[3:0], [4] and [6:5] shall be 0.
REQ-026 All uo_out and uio_out bits shall come from registers or constants only, with no combinational path from any input.
REQ-027 Latency: result nibble 0 is visible the cycle after beat 3 is accepted; full throughput is 4 load cycles plus 4 read cycles per add.

Reset
REQ-028 While rst_n=0, independent of clk:
- state = LOAD.
- write index = 0, read index = 0, carry = 0, result slots = 0.
REQ-029 Outputs under reset shall be: uo_out=0x00; uio_out=0x02 (in_ready=1, others 0); uio_oe=0x2A.
REQ-030 Reset asserted mid-LOAD or mid-OUT shall discard the operation with no residual state; the first beat after release is treated as beat 0.

Verification
REQ-031 Basic add, carry_in=0: beats (A,B) nibbles (4,1),(3,2),(2,3),(1,4), i.e. 0x1234 + 0x4321.
- Response: OUT reads 5,5,5,5 (0x5555), final carry 0, uo_out[6:5] = 0,1,2,3.
REQ-032 Overflow: 0xFFFF + 0x0001, i.e. beats (F,1),(F,0),(F,0),(F,0).
- Response: reads 0,0,0,0, final carry 1.
REQ-033 Carry-in: 0xFFFF + 0x0000 with carry_in=1 on beat 0.
- Response: result 0x0000, final carry 1.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles after entering OUT.
- Response: nibble 0 and index 0 held steady, in_ready=0, and in_valid pulses during OUT are ignored.
REQ-035 Abort after 2 beats, then a fresh 0x1111 + 0x2222.
- Response: busy drops the next cycle; result 0x3333, carry 0, with no contamination from the aborted beats.
REQ-036 rst_n pulsed low asynchronously during OUT at read index 2.
- Response: immediately uo_out=0x00, uio_out=0x02; the next add completes correctly.

Source files
------------

// File: rtl/tt_um_nibble_add_seq_if.sv
// Operand, handshake and result signals of the nibble-serial adder.
// The stimulus side takes the master modport and the adder takes the slave modport.
interface tt_um_nibble_add_seq_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_nibble_add_seq.sv
// 16-bit adder that shares one 4-bit adder over four operand beats, LS nibble first.
// The result is read back one nibble at a time under out_ready backpressure.
module tt_um_nibble_add_seq (
  input  logic                          clk,
  input  logic                          rst_n,
  tt_um_nibble_add_seq_if.slave         bus
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_OUT  = 1'b1
  } state_e;

  // Unpack the control bits that share the uio_in bus.
  logic       in_valid;
  logic       out_ready;
  logic       abort;
  logic       carry_in;
  logic [3:0] nib_a;
  logic [3:0] nib_b;

  assign in_valid  = bus.uio_in[0];
  assign out_ready = bus.uio_in[2];
  assign abort     = bus.uio_in[4];
  assign carry_in  = bus.uio_in[6];
  assign nib_a     = bus.ui_in[3:0];
  assign nib_b     = bus.ui_in[7:4];

  logic unused_uio_bits;
  assign unused_uio_bits = ^{bus.uio_in[7], bus.uio_in[5], bus.uio_in[3], bus.uio_in[1]};

  state_e     state_q, state_d;
  logic [1:0] wr_idx_q, wr_idx_d;
  logic [1:0] rd_idx_q, rd_idx_d;
  logic       carry_q, carry_d;
  logic [3:0] res_q [4];
  logic [3:0] res_d [4];
  logic [7:0] uo_out_q, uo_out_d;
  logic [7:0] uio_out_q, uio_out_d;

  // The single shared adder; beat 0 takes its carry from the pin, later beats chain.
  logic       beat_cin;
  logic [4:0] sum;

  always_comb begin
    beat_cin = (wr_idx_q == 2'd0) ? carry_in : carry_q;
    sum      = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, beat_cin};
  end

  // Next-state logic. ena=0 leaves every _d equal to its _q, so all state holds.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that skips
    // an assignment in always_comb would otherwise infer a latch.
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    carry_d  = carry_q;
    res_d    = res_q;

    if (bus.ena) begin
      if (abort) begin
        state_d  = ST_LOAD;
        wr_idx_d = 2'd0;
        rd_idx_d = 2'd0;
        carry_d  = 1'b0;
        for (int i = 0; i < 4; i++) begin
          res_d[i] = 4'h0;
        end
      end else begin
        unique case (state_q)
          ST_LOAD: begin
            if (in_valid) begin
              res_d[wr_idx_q] = sum[3:0];
              carry_d         = sum[4];
              wr_idx_d        = wr_idx_q + 2'd1;
              if (wr_idx_q == 2'd3) begin
                state_d  = ST_OUT;
                rd_idx_d = 2'd0;
              end
            end
          end
          ST_OUT: begin
            if (out_ready) begin
              if (rd_idx_q == 2'd3) begin
                state_d  = ST_LOAD;
                wr_idx_d = 2'd0;
                rd_idx_d = 2'd0;
                carry_d  = 1'b0;
              end else begin
                rd_idx_d = rd_idx_q + 2'd1;
              end
            end
          end
          default: state_d = ST_LOAD;
        endcase
      end
    end
  end

  // Outputs are decoded from next-state values and registered, so the pins
  // change in the same cycle as the state they describe yet never follow an
  // input combinationally.
  logic busy_d;
  logic out_valid_d;
  logic in_ready_d;

  always_comb begin
    out_valid_d = (state_d == ST_OUT);
    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_OUT) || (wr_idx_d != 2'd0);
    uo_out_d    = 8'h00;
    if (out_valid_d) begin
      uo_out_d = {1'b1, rd_idx_d, carry_d, res_d[rd_idx_d]};
    end
    uio_out_d = {2'b00, busy_d, 1'b0, out_valid_d, 1'b0, in_ready_d, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wr_idx_q  <= 2'd0;
      rd_idx_q  <= 2'd0;
      carry_q   <= 1'b0;
      // NOTE: the result slots are reset along with the control state so that a
      // sum interrupted by reset can never be read back by a later operation.
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= 4'h0;
      end
      uo_out_q  <= 8'h00;
      uio_out_q <= 8'h02;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      carry_q   <= carry_d;
      res_q     <= res_d;
      uo_out_q  <= uo_out_d;
      uio_out_q <= uio_out_d;
    end
  end

  assign bus.uo_out  = uo_out_q;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = 8'b0010_1010;

endmodule

// File: tb/tb_tt_um_nibble_add_seq.sv
// Self-checking bench for tt_um_nibble_add_seq: table-driven adds plus
// backpressure, abort, ena-stall and mid-read reset sequences, with a scoreboard queue.
module tb_tt_um_nibble_add_seq;

  logic clk;
  logic rst_n;

  tt_um_nibble_add_seq_if bus_if ();

  tt_um_nibble_add_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bits packed onto uio_in; the ignored bits are driven high on purpose.
  logic in_valid, out_ready, abort_r, carry_in;
  assign bus_if.uio_in = {1'b1, carry_in, 1'b1, abort_r, 1'b1, out_ready, 1'b1, in_valid};

  typedef struct packed {
    logic [3:0] nib;
    logic       carry;
    logic [1:0] idx;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'h0000, cin};
  endfunction

  task automatic push_expected(input logic [15:0] s, input logic c);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.nib   = s[4*i +: 4];
      e.carry = c;
      e.idx   = i[1:0];
      sb_q.push_back(e);
    end
  endtask

  // Four operand beats; carry_in is inverted on beats 1-3 to show it is ignored there.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input bit stall);
    for (int k = 0; k < 4; k++) begin
      bus_if.ui_in = {b[4*k +: 4], a[4*k +: 4]};
      in_valid     = 1'b1;
      carry_in     = (k == 0) ? cin : ~cin;
      out_ready    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k < 3) begin
        check("load_uio_out", bus_if.uio_out, 8'h22);
        check("load_uo_out", bus_if.uo_out, 8'h00);
      end
      if (stall && k == 1) begin
        bus_if.ena = 1'b0;
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
        end
        check("ena_hold_uio_out", bus_if.uio_out, 8'h22);
        bus_if.ena = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    carry_in  = 1'b0;
    check("latency_out_valid", bus_if.uo_out[7], 1'b1);
  endtask

  task automatic read_nibble(input string name);
    exp_t e;
    e = sb_q.pop_front();
    check(name, bus_if.uo_out, {1'b1, e.idx, e.carry, e.nib});
    check("out_uio_out", bus_if.uio_out, 8'h28);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < 4; i++) begin
      read_nibble(name);
    end
    check("back_to_load_uo_out", bus_if.uo_out, 8'h00);
    check("back_to_load_uio_out", bus_if.uio_out, 8'h02);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'hA5C3, 16'h7E19, 1'b0, 16'h23DC, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'h5A5A, 16'h0F0F, 1'b0, 16'h6969, 1'b0};

    rst_n        = 1'b0;
    bus_if.ena   = 1'b1;
    bus_if.ui_in = 8'h00;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    abort_r      = 1'b0;
    carry_in     = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_uo_out", bus_if.uo_out, 8'h00);
    check("reset_uio_out", bus_if.uio_out, 8'h02);
    check("reset_uio_oe", bus_if.uio_oe, 8'h2A);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_uio_out", bus_if.uio_out, 8'h02);

    // Table-driven adds; vector 3 also stalls with ena=0 mid-load.
    for (int i = 0; i < 7; i++) begin
      push_expected(vecs[i].exp_sum, vecs[i].exp_carry);
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, (i == 3));
      read_all($sformatf("vec%0d_read", i));
    end

    // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
    begin
      logic [16:0] r;
      exp_t        e0;
      r = model_add(16'h3C7E, 16'h91A5, 1'b0);
      push_expected(r[15:0], r[16]);
      do_add(16'h3C7E, 16'h91A5, 1'b0, 1'b0);
      e0 = sb_q[0];
      for (int c = 0; c < 10; c++) begin
        in_valid     = c[0];
        bus_if.ui_in = 8'($urandom_range(255));
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_uo_out", bus_if.uo_out, {1'b1, e0.idx, e0.carry, e0.nib});
        check("bp_in_ready_low", bus_if.uio_out[1], 1'b0);
      end
      in_valid = 1'b0;
      read_all("bp_read");
    end

    // Abort after two beats, with a simultaneous beat that must lose to abort.
    begin
      for (int k = 0; k < 2; k++) begin
        bus_if.ui_in = 8'hFF;
        in_valid     = 1'b1;
        carry_in     = 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
      check("pre_abort_busy", bus_if.uio_out[5], 1'b1);
      abort_r = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort_r  = 1'b0;
      in_valid = 1'b0;
      carry_in = 1'b0;
      check("abort_uio_out", bus_if.uio_out, 8'h02);
      check("abort_uo_out", bus_if.uo_out, 8'h00);
      push_expected(16'h3333, 1'b0);
      do_add(16'h1111, 16'h2222, 1'b0, 1'b0);
      read_all("post_abort_read");
    end

    // Asynchronous reset while reading nibble 2, then a clean add.
    begin
      logic [16:0] r;
      r = model_add(16'h9876, 16'h1357, 1'b0);
      push_expected(r[15:0], r[16]);
      do_add(16'h9876, 16'h1357, 1'b0, 1'b0);
      read_nibble("pre_reset_read");
      read_nibble("pre_reset_read");
      check("pre_reset_idx2", bus_if.uo_out[6:5], 2'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_uo_out", bus_if.uo_out, 8'h00);
      check("async_reset_uio_out", bus_if.uio_out, 8'h02);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_expected(16'h5000, 1'b0);
      do_add(16'h4444, 16'h0BBC, 1'b0, 1'b0);
      read_all("post_reset_read");
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
